// File: rtl/uart_core.sv
// Full-duplex UART with 16x oversampling, shared baud tick, optional parity and 1/2 stop bits.
// RX and TX each use their own FSM. The frame fields are set by parameters.
module uart_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  rxd,
  output logic                  txd,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       P_ODD     = (PARITY_ODD != 0);

  logic [DVSR_WIDTH-1:0] r_tick_cnt;
  logic                  w_tick;
  logic                  r_sync1, r_sync2;

  assign w_tick = (r_tick_cnt == dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + DVSR_WIDTH'(1);
      r_sync1    <= rxd;
      r_sync2    <= r_sync1;
    end
  end

  // ---------------- receiver ----------------
  state_t                r_rx_state, w_rx_next;
  logic [3:0]            r_rx_tcnt, r_rx_bcnt;
  logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data;
  logic                  r_rx_par, r_rx_ferr_acc;
  logic                  r_rx_valid, r_rx_perr, r_rx_ferr;
  logic                  w_rx_half, w_rx_mid, w_rx_done;

  assign w_rx_half = w_tick && (r_rx_tcnt == 4'd7);
  assign w_rx_mid  = w_tick && (r_rx_tcnt == 4'd15);
  assign w_rx_done = (r_rx_state == ST_STOP) && w_rx_mid && (r_rx_bcnt == LAST_STOP);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      ST_IDLE:   if (!r_sync2) w_rx_next = ST_START;
      ST_START:  if (w_rx_half) w_rx_next = r_sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_rx_mid && (r_rx_bcnt == LAST_BIT))
                   w_rx_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_rx_mid) w_rx_next = ST_STOP;
      ST_STOP:   if (w_rx_done) w_rx_next = ST_IDLE;
      default:   w_rx_next = ST_IDLE;
    endcase
  end

  // Tick and bit counters restart on every state change, so START's half-bit
  // count leaves DATA sampling at mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state    <= ST_IDLE;
      r_rx_tcnt     <= '0;
      r_rx_bcnt     <= '0;
      r_rx_shift    <= '0;
      r_rx_par      <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_perr     <= 1'b0;
      r_rx_ferr     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      if (r_rx_state != w_rx_next) begin
        r_rx_tcnt <= '0;
        r_rx_bcnt <= '0;
      end else begin
        if (w_tick)   r_rx_tcnt <= r_rx_tcnt + 4'd1;
        if (w_rx_mid) r_rx_bcnt <= r_rx_bcnt + 4'd1;
      end
      if (r_rx_state == ST_DATA && w_rx_mid)
        r_rx_shift <= {r_sync2, r_rx_shift[DATA_WIDTH-1:1]};
      if (r_rx_state == ST_PARITY && w_rx_mid)
        r_rx_par <= r_sync2;
      if (r_rx_state == ST_START)
        r_rx_ferr_acc <= 1'b0;
      else if (r_rx_state == ST_STOP && w_rx_mid && !r_sync2)
        r_rx_ferr_acc <= 1'b1;
      if (w_rx_done) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx_shift;
        r_rx_perr  <= (PARITY_EN != 0) && ((^r_rx_shift ^ r_rx_par) != P_ODD);
        r_rx_ferr  <= r_rx_ferr_acc | !r_sync2;
      end
    end
  end

  // ---------------- transmitter ----------------
  state_t                r_tx_state, w_tx_next;
  logic [3:0]            r_tx_tcnt, r_tx_bcnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic                  r_tx_par;
  logic                  w_tx_end;

  assign w_tx_end = w_tick && (r_tx_tcnt == 4'd15);

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      ST_IDLE:   if (tx_valid) w_tx_next = ST_START;
      ST_START:  if (w_tx_end) w_tx_next = ST_DATA;
      ST_DATA:   if (w_tx_end && (r_tx_bcnt == LAST_BIT))
                   w_tx_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tx_end) w_tx_next = ST_STOP;
      ST_STOP:   if (w_tx_end && (r_tx_bcnt == LAST_STOP)) w_tx_next = ST_IDLE;
      default:   w_tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (r_tx_state != w_tx_next) begin
        r_tx_tcnt <= '0;
        r_tx_bcnt <= '0;
      end else begin
        if (w_tick)   r_tx_tcnt <= r_tx_tcnt + 4'd1;
        if (w_tx_end) r_tx_bcnt <= r_tx_bcnt + 4'd1;
      end
      if (r_tx_state == ST_IDLE && tx_valid) begin
        r_tx_shift <= tx_data;
        r_tx_par   <= ^tx_data ^ P_ODD;
      end else if (r_tx_state == ST_DATA && w_tx_end) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  always_comb begin
    txd           = 1'b1;
    tx_ready      = 1'b0;
    case (r_tx_state)
      ST_IDLE:   tx_ready = 1'b1;
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = r_tx_shift[0];
      ST_PARITY: txd = r_tx_par;
      default:   txd = 1'b1;
    endcase
    rx_data       = r_rx_data;
    rx_valid      = r_rx_valid;
    rx_parity_err = r_rx_perr;
    rx_frame_err  = r_rx_ferr;
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1 instance (TX timing, loopback, errors, reset abort)
// plus an even-parity instance for the parity-error path.
module tb_uart_core;

  localparam int BITC = 64;  // clocks per bit at dvsr=3

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dvsr = 8'd0;
  logic       rx_line = 1'b1;
  logic       lb = 1'b0;
  logic       sel_par = 1'b0;
  logic       r_abort = 1'b0;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       txd, tx_ready, rx_valid, rx_parity_err, rx_frame_err;
  logic [7:0] rx_data;
  logic       w_rxd;

  logic [7:0] tx_data_p = 8'h00;
  logic       tx_valid_p = 1'b0;
  logic       txd_p, tx_ready_p, rx_valid_p, rx_parity_err_p, rx_frame_err_p;
  logic [7:0] rx_data_p;
  logic       w_rxd_p;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int rx_cnt_p = 0;

  always #5 clk = ~clk;

  assign w_rxd   = lb ? txd : (sel_par ? 1'b1 : rx_line);
  assign w_rxd_p = sel_par ? rx_line : 1'b1;

  uart_core #(.DATA_WIDTH(8), .DVSR_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rxd(w_rxd), .txd(txd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  uart_core #(.DATA_WIDTH(8), .DVSR_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rxd(w_rxd_p), .txd(txd_p),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_parity_err(rx_parity_err_p), .rx_frame_err(rx_frame_err_p)
  );

  always @(posedge clk) begin
    if (rx_valid)   rx_cnt   <= rx_cnt + 1;
    if (rx_valid_p) rx_cnt_p <= rx_cnt_p + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic rx_bit(input logic b, input int n);
    if (!r_abort) begin
      rx_line = b;
      for (int i = 0; i < n && !r_abort; i++) @(posedge clk);
      if (r_abort) rx_line = 1'b1;
    end
  endtask

  task automatic send_rx(input logic [8:0] d, input int nbits, input bit has_par,
                         input logic par, input logic stop, input int stop_clks);
    rx_bit(1'b0, BITC);
    for (int i = 0; i < nbits; i++) rx_bit(d[i], BITC);
    if (has_par) rx_bit(par, BITC);
    rx_bit(stop, stop_clks);
    rx_line = 1'b1;
  endtask

  initial begin
    logic [9:0] exp_bits;
    int base, base_p;
    exp_bits = 10'b1101001010;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_perr", rx_parity_err, 0);
    check("rst_ferr", rx_frame_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 8N1 TX at dvsr=0: 0xA5, each bit 16 clocks, busy requests ignored
    base = rx_cnt;
    start_tx(8'hA5);
    check("tx_ready_busy", tx_ready, 0);
    check("tx_start_now", txd, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("tx_bit%0d", k), txd, exp_bits[k]);
      if (k == 2) begin
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
      end
      if (k == 3) tx_valid = 1'b0;
      if (k == 9) begin
        repeat (7) @(posedge clk);
        #1;
        check("tx_ready_159", tx_ready, 0);
        @(posedge clk);
        #1;
        check("tx_ready_160", tx_ready, 1);
      end else begin
        repeat (8) @(posedge clk);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check("tx_idle_txd", txd, 1);
    check("tx_idle_ready", tx_ready, 1);
    check("tx_no_rx", rx_cnt - base, 0);

    // loopback at dvsr=3, 0x3C
    dvsr = 8'd3;
    lb   = 1'b1;
    repeat (10) @(posedge clk);
    base = rx_cnt;
    start_tx(8'h3C);
    repeat (800) @(posedge clk);
    #1;
    check("lb_count", rx_cnt - base, 1);
    check("lb_data", rx_data, 8'h3C);
    check("lb_perr", rx_parity_err, 0);
    check("lb_ferr", rx_frame_err, 0);
    lb = 1'b0;
    repeat (20) @(posedge clk);

    // frame error: 0x55 with stop bit low
    base = rx_cnt;
    send_rx(9'h055, 8, 0, 1'b0, 1'b0, 48);
    repeat (300) @(posedge clk);
    #1;
    check("ferr_count", rx_cnt - base, 1);
    check("ferr_data", rx_data, 8'h55);
    check("ferr_flag", rx_frame_err, 1);
    check("ferr_perr", rx_parity_err, 0);

    // 4-tick glitch on idle line
    base = rx_cnt;
    rx_line = 1'b0;
    repeat (16) @(posedge clk);
    rx_line = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_no_valid", rx_cnt - base, 0);
    check("glitch_ferr_held", rx_frame_err, 1);

    // even parity: 0x01 with parity 0 is bad, 0x03 with parity 0 is good
    sel_par = 1'b1;
    repeat (10) @(posedge clk);
    base_p = rx_cnt_p;
    send_rx(9'h001, 8, 1, 1'b0, 1'b1, BITC);
    repeat (100) @(posedge clk);
    #1;
    check("par_count", rx_cnt_p - base_p, 1);
    check("par_data", rx_data_p, 8'h01);
    check("par_err", rx_parity_err_p, 1);
    check("par_ferr", rx_frame_err_p, 0);
    send_rx(9'h003, 8, 1, 1'b0, 1'b1, BITC);
    repeat (100) @(posedge clk);
    #1;
    check("par_ok_data", rx_data_p, 8'h03);
    check("par_ok_err", rx_parity_err_p, 0);
    sel_par = 1'b0;
    repeat (20) @(posedge clk);

    // reset during TX data bit 3 and RX data bit 5
    base = rx_cnt;
    fork
      send_rx(9'h066, 8, 0, 1'b0, 1'b1, BITC);
      begin
        repeat (100) @(posedge clk);
        start_tx(8'hC3);
        repeat (300) @(posedge clk);
        #3;
        reset   = 1'b1;
        r_abort = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_ferr", rx_frame_err, 0);
        repeat (100) @(posedge clk);
      end
    join
    @(negedge clk);
    reset   = 1'b0;
    r_abort = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("post_rst_no_valid", rx_cnt - base, 0);
    check("post_rst_txd", txd, 1);

    lb = 1'b1;
    repeat (10) @(posedge clk);
    base = rx_cnt;
    start_tx(8'h7E);
    repeat (800) @(posedge clk);
    #1;
    check("post_rst_count", rx_cnt - base, 1);
    check("post_rst_data", rx_data, 8'h7E);
    check("post_rst_perr", rx_parity_err, 0);
    check("post_rst_ferr", rx_frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
